// File: rtl/event_log_ctrl.sv
// Alarm event log controller: circular-buffer bookkeeping around a single-port
// synchronous RAM (registered Q, one-cycle read latency, write-through).
// Event writes take priority over readback; reads are indexed from the oldest entry.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | accepting events or a readback request
// S_RD_ADDR | read address driven to RAM, RAM samples it on the next edge
// S_RD_CAP  | RAM Q holds the entry; result is registered on the next edge
module event_log_ctrl #(
    parameter int N         = 16,
    parameter int M         = 6,
    parameter int OVERWRITE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         ev_valid_i,
    input  logic [N-1:0] ev_data_i,
    output logic         ev_ready_o,
    input  logic         rd_req_i,
    input  logic [M-1:0] rd_idx_i,
    output logic         rd_ack_o,
    output logic         rd_valid_o,
    output logic [N-1:0] rd_data_o,
    output logic         rd_err_o,
    output logic [M:0]   count_o,
    output logic         full_o,
    output logic         overflow_o,
    output logic         ram_we_o,
    output logic [M-1:0] ram_a_o,
    output logic [N-1:0] ram_d_o,
    input  logic [N-1:0] ram_q_i
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_ADDR = 2'd1,
        S_RD_CAP  = 2'd2
    } state_t;

    localparam logic       OW_EN = (OVERWRITE != 0);
    localparam logic [M:0] DEPTH = {1'b1, {M{1'b0}}};

    state_t       state_q, state_d;
    logic [M-1:0] wr_ptr_q, wr_ptr_d;
    logic [M:0]   count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         ram_we_q, ram_we_d;
    logic [M-1:0] ram_a_q, ram_a_d;
    logic [N-1:0] ram_d_q, ram_d_d;
    logic         err_q, err_d;
    logic         rd_valid_q, rd_valid_d;
    logic [N-1:0] rd_data_q, rd_data_d;
    logic         rd_err_q, rd_err_d;

    logic         idle;
    logic         full;
    logic         wr_acc;
    logic [M-1:0] rd_phys;

    assign idle       = (state_q == S_IDLE);
    assign full       = (count_q == DEPTH);
    assign ev_ready_o = idle & ~clear_i & (~full | OW_EN);
    assign wr_acc     = ev_valid_i & ev_ready_o;
    assign rd_ack_o   = idle & ~clear_i & rd_req_i & ~wr_acc;
    // When full, count's low bits are zero, so the oldest entry sits at wr_ptr.
    assign rd_phys    = wr_ptr_q - count_q[M-1:0] + rd_idx_i;

    assign count_o    = count_q;
    assign full_o     = full;
    assign overflow_o = ovf_q;
    assign ram_we_o   = ram_we_q;
    assign ram_a_o    = ram_a_q;
    assign ram_d_o    = ram_d_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_err_o   = rd_err_q;

    // Next-state and datapath updates for write accept, read sequencing and clear.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        ram_we_d   = 1'b0;
        ram_a_d    = ram_a_q;
        ram_d_d    = ram_d_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;

        case (state_q)
            S_IDLE: begin
                if (wr_acc) begin
                    ram_we_d = 1'b1;
                    ram_a_d  = wr_ptr_q;
                    ram_d_d  = ev_data_i;
                    wr_ptr_d = wr_ptr_q + M'(1);
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + (M+1)'(1);
                    end
                end else if (rd_ack_o) begin
                    ram_a_d = rd_phys;
                    err_d   = ({1'b0, rd_idx_i} >= count_q);
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                rd_data_d  = err_q ? '0 : ram_q_i;
                rd_err_d   = err_q;
                rd_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A refused event while full is still an overflow, whatever the state.
        if (ev_valid_i & full & ~OW_EN & ~clear_i) begin
            ovf_d = 1'b1;
        end

        // Clear resets only the bookkeeping; an in-flight read carries on.
        if (clear_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_d_q    <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ram_we_q   <= ram_we_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
        end
    end

endmodule
